multiplexer_2to1: RTL and testbench
===================================

// Module: multiplexer_2to1
// PURPOSE
//  - 2:1 data selector: muxout follows line0 when select=0, line1 when select=1.
//  - Leaf primitive used wherever a datapath picks between two sources.
//  - Combinational primary output (zero latency).
//  - Registered copy and select-change flag for pipelined or observing consumers.
// PARAMETERS
//  - WIDTH     default 1   bit width of line0, line1, muxout, muxout_q.
//  - RESET_VAL default '0  value loaded into muxout_q on reset.
// PORTS
//  - clk         in   1      single clock; all state updates on rising edge.
//  - rst         in   1      reset, synchronous, active-high.
//  - select      in   1      source select: 0 -> line0, 1 -> line1.
//  - line0       in   WIDTH  data source 0.
//  - line1       in   WIDTH  data source 1.
//  - muxout      out  WIDTH  combinational selected data.
//  - muxout_q    out  WIDTH  muxout registered; 1-cycle latency.
//  - sel_changed out  1      registered; high for 1 cycle after select differs from its previous sampled value.
// BEHAVIOUR
//  - Interface: one clock (clk); reset rst is synchronous and active-high.
//  - muxout = select ? line1 : line0.
//    - Purely combinational; no clock dependency.
//    - Responds within the same delta to any change on select, line0 or line1.
//    - Unaffected by rst.
//  - Select unknown (X/Z), simulation only:
//    - each bit of muxout = the common value where line0 and line1 agree;
//    - X where line0 and line1 differ (ternary-operator semantics).
//  - muxout_q: on rising clk, rst=1 -> RESET_VAL; else <= muxout.
//  - sel_prev (internal): on rising clk, rst=1 -> 0; else <= select.
//  - sel_changed: on rising clk, rst=1 -> 0; else <= (select != sel_prev).
//  - Reset mid-operation:
//    - muxout_q and sel_changed clear on the clk edge where rst=1;
//    - muxout keeps tracking its inputs throughout.
//  - First cycle after reset release with select=1: sel_changed=1 at the next edge (sel_prev reset to 0).
//  - Simultaneous select and data change: muxout reflects the new select applied to the new data.
//  - No other state, handshake or backpressure; block always accepts inputs.
// TESTING
//  - select=0, line0/line1 swept 00,10,01,11 -> muxout = line0: 0,1,0,1.
//  - select=1, line0/line1 swept 01,00,10,11 -> muxout = line1: 1,0,0,1.
//  - rst=1 for 2 clks, inputs arbitrary -> muxout_q=RESET_VAL, sel_changed=0; muxout still = selected line.
//  - rst=0, select=0, line0=1 held 1 clk -> muxout_q=1 one clk after muxout=1.
//  - Toggle select 0->1 for one clk, then hold -> sel_changed=1 for exactly 1 clk, then 0.
//  - select=X, line0=line1=1 -> muxout=1; select=X, line0=0, line1=1 -> muxout=X.
//  - WIDTH=8, line0=8'hA5, line1=8'h3C -> muxout 8'hA5 (select=0), 8'h3C (select=1).

Source files
------------

// File: rtl/multiplexer_2to1.sv
// ---------------------------------------------------------------------------
// multiplexer_2to1
//   2:1 data selector leaf. It provides three outputs:
//   - muxout: a zero-latency combinational path.
//   - muxout_q: a registered copy of muxout.
//   - sel_changed: a flag that goes high for one cycle after select changes.
//
// Parameters
//   WIDTH       data width of line0/line1/muxout/muxout_q
//   RESET_VAL   value loaded into muxout_q while rst is high
//
// Ports
//   clk          rising-edge clock for all state
//   rst          synchronous, active-high reset
//   select       0 -> line0, 1 -> line1
//   line0/line1  data sources
//   muxout       combinational selected data; rst does not affect it
//   muxout_q     muxout delayed by one clk
//   sel_changed  high for one clk after select differs from its last sample
// ---------------------------------------------------------------------------
module multiplexer_2to1 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             select,
  input  logic [WIDTH-1:0] line0,
  input  logic [WIDTH-1:0] line1,
  output logic [WIDTH-1:0] muxout,
  output logic [WIDTH-1:0] muxout_q,
  output logic             sel_changed
);

  logic sel_prev;

  // The ternary form is deliberate. When select is unknown in simulation,
  // bits where both lines agree resolve to that common value. Bits where
  // the lines differ go to X. An if/case form would silently pick one side.
  assign muxout = select ? line1 : line0;

  // sel_prev resets to 0. As a result, releasing reset with select=1 reports
  // a change on the first edge after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      muxout_q    <= RESET_VAL;
      sel_prev    <= 1'b0;
      sel_changed <= 1'b0;
    end else begin
      muxout_q    <= muxout;
      sel_prev    <= select;
      sel_changed <= (select != sel_prev);
    end
  end

endmodule

// File: tb/tb_multiplexer_2to1.sv
module tb_multiplexer_2to1;

  localparam logic [7:0] RV8 = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       select;
  logic       line0, line1;
  logic       muxout, muxout_q, sel_changed;
  logic [7:0] w0, w1, wout, wout_q;
  logic       wsel_changed;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  multiplexer_2to1 u_dut1 (
    .clk(clk), .rst(rst), .select(select), .line0(line0), .line1(line1),
    .muxout(muxout), .muxout_q(muxout_q), .sel_changed(sel_changed)
  );

  multiplexer_2to1 #(.WIDTH(8), .RESET_VAL(RV8)) u_dut8 (
    .clk(clk), .rst(rst), .select(select), .line0(w0), .line1(w1),
    .muxout(wout), .muxout_q(wout_q), .sel_changed(wsel_changed)
  );

  // Advance one clock edge, then settle 1 ns so the registered outputs are
  // sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; select = 1'b1; line0 = 1'b0; line1 = 1'b1; w0 = 8'h11; w1 = 8'h22;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (muxout_q !== 1'b0) begin errors++; $display("FAIL reset_q1[%0d] got %b want 0", i, muxout_q); end
      vectors++;
      if (wout_q !== RV8) begin errors++; $display("FAIL reset_q8[%0d] got %h want %h", i, wout_q, RV8); end
      vectors++;
      if (sel_changed !== 1'b0) begin errors++; $display("FAIL reset_selchg[%0d] got %b want 0", i, sel_changed); end
      vectors++;
      if (muxout !== 1'b1) begin errors++; $display("FAIL reset_muxout[%0d] got %b want 1", i, muxout); end
      vectors++;
      if (wout !== 8'h22) begin errors++; $display("FAIL reset_muxout8[%0d] got %h want 22", i, wout); end
    end
  endtask

  task automatic test_sel0();
    logic [1:0] pat [4] = '{2'b00, 2'b10, 2'b01, 2'b11}; // {line0,line1}
    logic       exp [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    select = 1'b0;
    for (int i = 0; i < 4; i++) begin
      line0 = pat[i][1]; line1 = pat[i][0];
      #1;
      vectors++;
      if (muxout !== exp[i]) begin errors++; $display("FAIL sel0[%0d] got %b want %b", i, muxout, exp[i]); end
    end
  endtask

  task automatic test_sel1();
    logic [1:0] pat [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic       exp [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    select = 1'b1;
    for (int i = 0; i < 4; i++) begin
      line0 = pat[i][1]; line1 = pat[i][0];
      #1;
      vectors++;
      if (muxout !== exp[i]) begin errors++; $display("FAIL sel1[%0d] got %b want %b", i, muxout, exp[i]); end
    end
  endtask

  task automatic test_register();
    rst = 1'b0; select = 1'b0; line0 = 1'b0; line1 = 1'b0;
    tick(); tick();
    line0 = 1'b1;
    #1;
    vectors++;
    if (muxout !== 1'b1) begin errors++; $display("FAIL reg_comb got %b want 1", muxout); end
    vectors++;
    if (muxout_q !== 1'b0) begin errors++; $display("FAIL reg_before got %b want 0", muxout_q); end
    tick();
    vectors++;
    if (muxout_q !== 1'b1) begin errors++; $display("FAIL reg_after got %b want 1", muxout_q); end
  endtask

  task automatic test_sel_toggle();
    logic exp [3] = '{1'b1, 1'b0, 1'b0};
    rst = 1'b0; select = 1'b0;
    tick(); tick();
    vectors++;
    if (sel_changed !== 1'b0) begin errors++; $display("FAIL toggle_idle got %b want 0", sel_changed); end
    select = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (sel_changed !== exp[i]) begin errors++; $display("FAIL toggle[%0d] got %b want %b", i, sel_changed, exp[i]); end
    end
    // A return to 0 is also a change.
    select = 1'b0;
    tick();
    vectors++;
    if (sel_changed !== 1'b1) begin errors++; $display("FAIL toggle_back got %b want 1", sel_changed); end
  endtask

  task automatic test_wide();
    rst = 1'b0; w0 = 8'hA5; w1 = 8'h3C;
    select = 1'b0; #1;
    vectors++;
    if (wout !== 8'hA5) begin errors++; $display("FAIL wide_sel0 got %h want a5", wout); end
    tick();
    vectors++;
    if (wout_q !== 8'hA5) begin errors++; $display("FAIL wide_q0 got %h want a5", wout_q); end
    select = 1'b1; #1;
    vectors++;
    if (wout !== 8'h3C) begin errors++; $display("FAIL wide_sel1 got %h want 3c", wout); end
    tick();
    vectors++;
    if (wout_q !== 8'h3C) begin errors++; $display("FAIL wide_q1 got %h want 3c", wout_q); end
    // Changing select and data together shows the new select applied to the
    // new data.
    select = 1'b0; w0 = 8'hC3; w1 = 8'h0F; #1;
    vectors++;
    if (wout !== 8'hC3) begin errors++; $display("FAIL wide_simul got %h want c3", wout); end
  endtask

  task automatic test_reset_mid();
    rst = 1'b0; select = 1'b0; line0 = 1'b1; line1 = 1'b0;
    tick();
    select = 1'b1; line1 = 1'b1;
    tick(); // muxout_q=1, sel_changed=1 going into reset
    rst = 1'b1;
    tick();
    vectors++;
    if (muxout_q !== 1'b0) begin errors++; $display("FAIL mid_q got %b want 0", muxout_q); end
    vectors++;
    if (sel_changed !== 1'b0) begin errors++; $display("FAIL mid_selchg got %b want 0", sel_changed); end
    line1 = 1'b0; #1;
    vectors++;
    if (muxout !== 1'b0) begin errors++; $display("FAIL mid_comb got %b want 0", muxout); end
    // Release reset with select still 1. Because sel_prev was cleared,
    // a change is flagged.
    rst = 1'b0;
    tick();
    vectors++;
    if (sel_changed !== 1'b1) begin errors++; $display("FAIL release_selchg got %b want 1", sel_changed); end
    tick();
    vectors++;
    if (sel_changed !== 1'b0) begin errors++; $display("FAIL release_hold got %b want 0", sel_changed); end
  endtask

  task automatic test_xsel();
    logic probe;
    probe = 1'bx;
    select = 1'bx; line0 = 1'b1; line1 = 1'b1; #1;
    vectors++;
    if (muxout !== 1'b1) begin errors++; $display("FAIL xsel_agree got %b want 1", muxout); end
    // The X-propagation case can only be observed on a four-state simulator.
    if (probe === 1'bx) begin
      line0 = 1'b0; #1;
      vectors++;
      if (muxout !== 1'bx) begin errors++; $display("FAIL xsel_differ got %b want x", muxout); end
    end
    select = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; select = 1'b0; line0 = 1'b0; line1 = 1'b0; w0 = '0; w1 = '0;
    #2;
    test_reset();
    test_sel0();
    test_sel1();
    test_register();
    test_sel_toggle();
    test_wide();
    test_reset_mid();
    test_xsel();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
